// File: rtl/sram_fifo_ctrl_if.sv
// Push/pop stream bundle between datapath producers/consumers and the SRAM FIFO controller.
// Handshake: a word moves on a cycle where valid && ready; valid never waits on ready.
interface sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 9
) ();
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [DATA_WIDTH-1:0] pop_data;
  logic [ADDR_WIDTH+1:0] count;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, count
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, count
  );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of a 1R1W SRAM macro; a 2-entry output buffer
// absorbs the one-cycle read latency so push and pop each run at full rate.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 9,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_fifo_ctrl_if.slave       fifo,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   sram_used;
  logic                  rd_inflight;
  logic [1:0]            out_cnt;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] obuf [2];

  logic                  push_fire;
  logic                  pop_fire;
  logic                  rd_fire;
  logic [2:0]            occ_after_pop;

  always_comb begin
    sram_used       = wr_ptr - rd_ptr;
    fifo.push_ready = !rst && (sram_used < DEPTH_P);
    fifo.pop_valid  = !rst && (out_cnt != 2'd0);
    fifo.pop_data   = obuf[head];
    push_fire       = fifo.push_valid && fifo.push_ready;
    pop_fire        = fifo.pop_valid && fifo.pop_ready;
    tail            = head ^ out_cnt[0];
    // Only issue a read if the buffer slot it lands in is guaranteed free.
    occ_after_pop   = {1'b0, out_cnt} + {2'b00, rd_inflight} - {2'b00, pop_fire};
    rd_fire         = !rst && (sram_used != '0) && (occ_after_pop < 3'd2);

    sram_csb0  = !push_fire;
    sram_addr0 = rst ? '0 : wr_ptr[ADDR_WIDTH-1:0];
    sram_din0  = fifo.push_data;
    sram_csb1  = !rd_fire;
    sram_addr1 = rst ? '0 : rd_ptr[ADDR_WIDTH-1:0];

    fifo.count = rst ? '0 : ({1'b0, sram_used}
                             + (ADDR_WIDTH+2)'(rd_inflight)
                             + (ADDR_WIDTH+2)'(out_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
      out_cnt     <= 2'd0;
      head        <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire)   rd_ptr <= rd_ptr + 1'b1;
      rd_inflight <= rd_fire;
      if (pop_fire)  head <= ~head;
      out_cnt <= out_cnt + {1'b0, rd_inflight} - {1'b0, pop_fire};
    end
  end

  // dout1 is only meaningful the cycle after a read; it is X otherwise.
  always_ff @(posedge clk) begin
    if (!rst && rd_inflight) obuf[tail] <= sram_dout1;
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed and random bench for sram_fifo_ctrl with a behavioural 1R1W SRAM model.
module tb_sram_fifo_ctrl;
  localparam int DW = 128;
  localparam int AW = 9;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          sram_csb0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1;
  logic [DW-1:0] mem [DEPTH];

  sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifo ();

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo       (fifo.slave),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // SRAM macro model: dout1 is X except the cycle after a read
  always @(posedge clk) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    else            sram_dout1 <= 'x;
  end

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int unsigned   wr_cnt = 0;
  int unsigned   rd_cnt = 0;
  int            n_popped = 0;
  logic          last_push_fire;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: drive at negedge, settle, book-keep, then advance one cycle with tick
  task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic pr);
    fifo.push_valid = pv;
    fifo.push_data  = pd;
    fifo.pop_ready  = pr;
    #1;
    last_push_fire = pv && fifo.push_ready;
    check("no_rw_collision", {{(DW-1){1'b0}}, (!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1)}, '0);
    if (rst) begin
      check("rst_csb0", sram_csb0, 1'b1);
      check("rst_csb1", sram_csb1, 1'b1);
    end
    if (last_push_fire) begin
      check("wr_csb0", sram_csb0, 1'b0);
      check("wr_addr0", sram_addr0, wr_cnt % DEPTH);
      check("wr_din0", sram_din0, pd);
      exp_q.push_back(pd);
      wr_cnt++;
    end else begin
      check("idle_csb0", sram_csb0, 1'b1);
    end
    if (!sram_csb1) begin
      check("rd_addr1", sram_addr1, rd_cnt % DEPTH);
      rd_cnt++;
    end
    if (fifo.pop_valid && pr) begin
      if (exp_q.size() == 0) check("pop_unexpected", fifo.pop_valid, 1'b0);
      else check("pop_data", fifo.pop_data, exp_q.pop_front());
      n_popped++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, {4{$urandom}}, 1'b1);
      check("rst_push_ready", fifo.push_ready, 1'b0);
      check("rst_pop_valid", fifo.pop_valid, 1'b0);
      check("rst_count", fifo.count, '0);
      tick();
    end
    rst = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < budget) begin
      drive(1'b0, '0, 1'b1);
      tick();
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
    drive(1'b0, '0, 1'b0);
    check("drain_count", fifo.count, '0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int waited;
    rst = 1'b1;
    fifo.push_valid = 1'b0;
    fifo.push_data  = '0;
    fifo.pop_ready  = 1'b0;
    @(negedge clk);

    // reset with push_valid held high
    do_reset(3);
    drive(1'b0, '0, 1'b0);
    check("post_rst_push_ready", fifo.push_ready, 1'b1);
    check("post_rst_pop_valid", fifo.pop_valid, 1'b0);
    tick();

    // single word latency: write c0, read c1, capture end of c2, pop_valid c3
    drive(1'b1, {16{8'hA5}}, 1'b1);
    check("single_csb0", sram_csb0, 1'b0);
    check("single_addr0", sram_addr0, '0);
    tick();
    drive(1'b0, '0, 1'b1);
    check("single_csb1", sram_csb1, 1'b0);
    check("single_addr1", sram_addr1, '0);
    tick();
    drive(1'b0, '0, 1'b1);
    check("single_c2_pop_valid", fifo.pop_valid, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1);
    check("single_c3_pop_valid", fifo.pop_valid, 1'b1);
    check("single_c3_popped", exp_q.size(), 0);
    tick();
    drive(1'b0, '0, 1'b0);
    check("single_count", fifo.count, '0);
    tick();

    // fill with no pops: 512 in SRAM plus 2 in the output buffer
    accepted = 0;
    for (int i = 0; i <= 600; i++) begin
      drive(1'b1, DW'(i), 1'b0);
      if (last_push_fire) accepted++;
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("fill_accepted", accepted, 514);
    check("fill_count", fifo.count, 514);
    check("fill_push_ready", fifo.push_ready, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    waited = 1;
    if (!fifo.push_ready) begin
      drive(1'b0, '0, 1'b0);
      tick();
      waited++;
    end
    check("fill_ready_reopen", fifo.push_ready, 1'b1);
    drain(1000);

    // streaming one push and one pop per cycle
    for (int i = 0; i < 2000; i++) begin
      drive(1'b1, DW'(i), 1'b1);
      if (i >= 3) begin
        check("stream_pop_valid", fifo.pop_valid, 1'b1);
        check("stream_count", fifo.count, 3);
      end
      tick();
    end
    drain(100);

    // random valid/ready over 10k cycles
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)));
      tick();
    end
    drain(1000);

    // reset while a read is in flight and the buffer holds a word
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(10 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1);
    check("midrst_read_issued", sram_csb1, 1'b0);
    tick();
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b0);
      check("midrst_pop_valid", fifo.pop_valid, 1'b0);
      check("midrst_count", fifo.count, '0);
      tick();
    end
    n_popped = 0;
    drive(1'b1, DW'(1), 1'b1);
    tick();
    waited = 0;
    while (n_popped == 0 && waited < 10) begin
      drive(1'b0, '0, 1'b1);
      tick();
      waited++;
    end
    check("midrst_new_word_popped", n_popped, 1);
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
